// File: rtl/layer_tile_scheduler_pkg.sv
// Shared definitions for layer_tile_scheduler: FSM state encoding and
// helpers that derive the layer geometry constants from the top parameters.
package layer_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Input feature-map width for a stride-1, unpadded kernel.
  function automatic int unsigned ifm_width_f(input int unsigned ofm_w, input int unsigned k);
    return ofm_w + k - 1;
  endfunction

  // Number of column tiles per output row (ceiling division).
  function automatic int unsigned nct_f(input int unsigned ofm_w, input int unsigned s);
    return (ofm_w + s - 1) / s;
  endfunction

  // Number of filter groups.
  function automatic int unsigned nfg_f(input int unsigned nf, input int unsigned s);
    return nf / s;
  endfunction

  // Weight words per filter group.
  function automatic int unsigned wgt_group_stride_f(input int unsigned s, input int unsigned k,
                                                     input int unsigned c);
    return s * k * k * c;
  endfunction

  // Output words per filter group.
  function automatic int unsigned ofm_group_stride_f(input int unsigned s, input int unsigned h,
                                                     input int unsigned w);
    return s * h * w;
  endfunction

  // Valid columns in the last tile of a row (0 means the tile is full).
  function automatic int unsigned col_rem_f(input int unsigned w, input int unsigned s);
    return w % s;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_tile_scheduler_if.sv
// Tile handshake between layer_tile_scheduler (master) and main_controller (slave).
interface layer_tile_scheduler_if #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned SYSTOLIC_SIZE = 16
);
  logic                     tile_start;
  logic                     tile_done;
  logic [ADDR_W-1:0]        ifm_base_addr;
  logic [ADDR_W-1:0]        wgt_base_addr;
  logic [ADDR_W-1:0]        ofm_base_addr;
  logic [SYSTOLIC_SIZE-1:0] col_valid;
  logic                     wgt_reload;

  modport master (
    output tile_start, ifm_base_addr, wgt_base_addr, ofm_base_addr, col_valid, wgt_reload,
    input  tile_done
  );

  modport slave (
    input  tile_start, ifm_base_addr, wgt_base_addr, ofm_base_addr, col_valid, wgt_reload,
    output tile_done
  );
endinterface

// File: rtl/layer_tile_scheduler_tile_addr_gen.sv
// Tile counters (fg/row/col_tile) and incrementally maintained base addresses.
// clear loads tile (0,0,0); advance steps to the next tile in col->row->fg order.
// All address, mask and reload outputs come straight from flops.
module layer_tile_scheduler_tile_addr_gen
  import layer_tile_scheduler_pkg::*;
#(
  parameter int unsigned NO_FILTER     = 32,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned OFM_WIDTH     = 416,
  parameter int unsigned OFM_HEIGHT    = 416,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  output logic [ADDR_W-1:0]        ifm_base_addr,
  output logic [ADDR_W-1:0]        wgt_base_addr,
  output logic [ADDR_W-1:0]        ofm_base_addr,
  output logic [SYSTOLIC_SIZE-1:0] col_valid,
  output logic                     wgt_reload,
  output logic                     last_tile
);

  localparam int unsigned IFM_WIDTH = ifm_width_f(OFM_WIDTH, KERNEL_SIZE);
  localparam int unsigned NCT       = nct_f(OFM_WIDTH, SYSTOLIC_SIZE);
  localparam int unsigned NFG       = nfg_f(NO_FILTER, SYSTOLIC_SIZE);
  localparam int unsigned WGS       = wgt_group_stride_f(SYSTOLIC_SIZE, KERNEL_SIZE, NO_CHANNEL);
  localparam int unsigned OGS       = ofm_group_stride_f(SYSTOLIC_SIZE, OFM_HEIGHT, OFM_WIDTH);
  localparam int unsigned COL_REM   = col_rem_f(OFM_WIDTH, SYSTOLIC_SIZE);

  localparam int unsigned COL_W = cnt_width_f(NCT);
  localparam int unsigned ROW_W = cnt_width_f(OFM_HEIGHT);
  localparam int unsigned FG_W  = cnt_width_f(NFG);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NCT - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OFM_HEIGHT - 1);
  localparam logic [FG_W-1:0]  FG_MAX  = FG_W'(NFG - 1);

  localparam logic [SYSTOLIC_SIZE-1:0] ALL_MASK   = '1;
  localparam logic [SYSTOLIC_SIZE-1:0] LAST_MASK  =
    (COL_REM == 0) ? ALL_MASK : SYSTOLIC_SIZE'((64'd1 << COL_REM) - 64'd1);
  // With a single column tile per row, tile 0 is also the partial tile.
  localparam logic [SYSTOLIC_SIZE-1:0] FIRST_MASK = (NCT == 1) ? LAST_MASK : ALL_MASK;

  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(SYSTOLIC_SIZE);
  localparam logic [ADDR_W-1:0] IFW_STEP = ADDR_W'(IFM_WIDTH);
  localparam logic [ADDR_W-1:0] OFW_STEP = ADDR_W'(OFM_WIDTH);
  localparam logic [ADDR_W-1:0] WGS_STEP = ADDR_W'(WGS);
  localparam logic [ADDR_W-1:0] OGS_STEP = ADDR_W'(OGS);

  logic [FG_W-1:0]          fg_q, fg_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ADDR_W-1:0]        ifm_row_q, ifm_row_d;   // row*IFM_WIDTH
  logic [ADDR_W-1:0]        ifm_q, ifm_d;
  logic [ADDR_W-1:0]        wgt_q, wgt_d;
  logic [ADDR_W-1:0]        ofm_fg_q, ofm_fg_d;     // fg*OFM group stride
  logic [ADDR_W-1:0]        ofm_row_q, ofm_row_d;   // group base + row*OFM_WIDTH
  logic [ADDR_W-1:0]        ofm_q, ofm_d;
  logic [SYSTOLIC_SIZE-1:0] col_valid_q, col_valid_d;
  logic                     wgt_reload_q, wgt_reload_d;

  // Next-tile computation: counters wrap innermost first, addresses advance by adds only.
  always_comb begin
    fg_d         = fg_q;
    row_d        = row_q;
    col_d        = col_q;
    ifm_row_d    = ifm_row_q;
    ifm_d        = ifm_q;
    wgt_d        = wgt_q;
    ofm_fg_d     = ofm_fg_q;
    ofm_row_d    = ofm_row_q;
    ofm_d        = ofm_q;
    col_valid_d  = col_valid_q;
    wgt_reload_d = wgt_reload_q;
    if (clear) begin
      fg_d         = '0;
      row_d        = '0;
      col_d        = '0;
      ifm_row_d    = '0;
      ifm_d        = '0;
      wgt_d        = '0;
      ofm_fg_d     = '0;
      ofm_row_d    = '0;
      ofm_d        = '0;
      col_valid_d  = FIRST_MASK;
      wgt_reload_d = 1'b1;
    end else if (advance) begin
      if (col_q != COL_MAX) begin
        col_d        = col_q + COL_W'(1);
        ifm_d        = ifm_q + COL_STEP;
        ofm_d        = ofm_q + COL_STEP;
        col_valid_d  = (col_d == COL_MAX) ? LAST_MASK : ALL_MASK;
        wgt_reload_d = 1'b0;
      end else begin
        col_d       = '0;
        col_valid_d = FIRST_MASK;
        if (row_q != ROW_MAX) begin
          row_d        = row_q + ROW_W'(1);
          ifm_row_d    = ifm_row_q + IFW_STEP;
          ifm_d        = ifm_row_d;
          ofm_row_d    = ofm_row_q + OFW_STEP;
          ofm_d        = ofm_row_d;
          wgt_reload_d = 1'b0;
        end else begin
          row_d        = '0;
          fg_d         = fg_q + FG_W'(1);
          ifm_row_d    = '0;
          ifm_d        = '0;
          wgt_d        = wgt_q + WGS_STEP;
          ofm_fg_d     = ofm_fg_q + OGS_STEP;
          ofm_row_d    = ofm_fg_d;
          ofm_d        = ofm_fg_d;
          wgt_reload_d = 1'b1;
        end
      end
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ifm_row_q    <= '0;
      ifm_q        <= '0;
      wgt_q        <= '0;
      ofm_fg_q     <= '0;
      ofm_row_q    <= '0;
      ofm_q        <= '0;
      col_valid_q  <= '0;
      wgt_reload_q <= 1'b0;
    end else begin
      fg_q         <= fg_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ifm_row_q    <= ifm_row_d;
      ifm_q        <= ifm_d;
      wgt_q        <= wgt_d;
      ofm_fg_q     <= ofm_fg_d;
      ofm_row_q    <= ofm_row_d;
      ofm_q        <= ofm_d;
      col_valid_q  <= col_valid_d;
      wgt_reload_q <= wgt_reload_d;
    end
  end

  assign ifm_base_addr = ifm_q;
  assign wgt_base_addr = wgt_q;
  assign ofm_base_addr = ofm_q;
  assign col_valid     = col_valid_q;
  assign wgt_reload    = wgt_reload_q;
  assign last_tile     = (fg_q == FG_MAX) && (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/layer_tile_scheduler.sv
// Layer tile scheduler: walks one convolution layer tile by tile, handing each
// tile to main_controller through the tile interface and waiting for tile_done.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | tile_start pulse, tile parameters valid
// WAIT    | waiting for main_controller tile_done
// ADVANCE | step to next tile or finish
// DONE    | done pulse
//
// Optional: define LAYER_TILE_SCHEDULER_PERF_EN to add cycle_cnt/tile_cnt outputs.
module layer_tile_scheduler
  import layer_tile_scheduler_pkg::*;
#(
  parameter int unsigned NO_FILTER     = 32,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned OFM_WIDTH     = 416,
  parameter int unsigned OFM_HEIGHT    = 416,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  layer_tile_scheduler_if.master  tile_bus
`ifdef LAYER_TILE_SCHEDULER_PERF_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             tile_cnt
`endif
);

  state_e state_q, state_d;
  logic   clear_s;
  logic   advance_s;
  logic   last_tile;
  logic   tile_accept;

  // tile_done counts only while waiting; pulses in ISSUE or IDLE are dropped.
  assign tile_accept = (state_q == ST_WAIT) && tile_bus.tile_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and counter strobes.
  always_comb begin
    state_d   = state_q;
    clear_s   = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_s = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tile_accept) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (last_tile) begin
          state_d = ST_DONE;
        end else begin
          advance_s = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy                = (state_q != ST_IDLE);
  assign done                = (state_q == ST_DONE);
  assign tile_bus.tile_start = (state_q == ST_ISSUE);

  layer_tile_scheduler_tile_addr_gen #(
    .NO_FILTER     (NO_FILTER),
    .KERNEL_SIZE   (KERNEL_SIZE),
    .NO_CHANNEL    (NO_CHANNEL),
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .OFM_WIDTH     (OFM_WIDTH),
    .OFM_HEIGHT    (OFM_HEIGHT),
    .ADDR_W        (ADDR_W)
  ) u_tile_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear_s),
    .advance       (advance_s),
    .ifm_base_addr (tile_bus.ifm_base_addr),
    .wgt_base_addr (tile_bus.wgt_base_addr),
    .ofm_base_addr (tile_bus.ofm_base_addr),
    .col_valid     (tile_bus.col_valid),
    .wgt_reload    (tile_bus.wgt_reload),
    .last_tile     (last_tile)
  );

`ifdef LAYER_TILE_SCHEDULER_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] tile_cnt_q, tile_cnt_d;

  // Performance counters: cleared on layer start, held after done.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    if (clear_s) begin
      cycle_cnt_d = '0;
      tile_cnt_d  = '0;
    end else begin
      if (busy)        cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (tile_accept) tile_cnt_d  = tile_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      tile_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign tile_cnt  = tile_cnt_q;
`endif

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Scoreboard bench for layer_tile_scheduler on a 20x2 output map, 32 filters.
module tb_layer_tile_scheduler;

  localparam int NF  = 32;
  localparam int K   = 3;
  localparam int C   = 3;
  localparam int S   = 16;
  localparam int W   = 20;
  localparam int H   = 2;
  localparam int AW  = 32;
  localparam int IFW = W + K - 1;
  localparam int NCT = (W + S - 1) / S;
  localparam int NFG = NF / S;
  localparam int NT  = NFG * H * NCT;

  typedef struct packed {
    logic [31:0] ifm;
    logic [31:0] wgt;
    logic [31:0] ofm;
    logic [15:0] cv;
    logic        rl;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic resp_done = 1'b0;
  logic idle_done = 1'b0;

  layer_tile_scheduler_if #(.ADDR_W(AW), .SYSTOLIC_SIZE(S)) bus ();
  assign bus.tile_done = resp_done | idle_done;

`ifdef LAYER_TILE_SCHEDULER_PERF_EN
  logic [31:0] cycle_cnt, tile_cnt;
`endif

  layer_tile_scheduler #(
    .NO_FILTER(NF), .KERNEL_SIZE(K), .NO_CHANNEL(C), .SYSTOLIC_SIZE(S),
    .OFM_WIDTH(W), .OFM_HEIGHT(H), .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .tile_bus (bus)
`ifdef LAYER_TILE_SCHEDULER_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .tile_cnt (tile_cnt)
`endif
  );

  always #5 clk = ~clk;

  tile_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_req = 0;
  int    done_got = 0;
  int    lat_fixed = 5;
  bit    noise = 1'b0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: enumerate the layer's tiles in loop order from the address formulas.
  task automatic push_layer();
    tile_t t;
    for (int fg = 0; fg < NFG; fg++)
      for (int row = 0; row < H; row++)
        for (int col = 0; col < NCT; col++) begin
          t.ifm = 32'(row * IFW + col * S);
          t.wgt = 32'(fg * S * K * K * C);
          t.ofm = 32'(fg * S * H * W + row * W + col * S);
          for (int i = 0; i < S; i++) t.cv[i] = (col * S + i < W);
          t.rl = (row == 0) && (col == 0);
          exp_q.push_back(t);
        end
    done_req++;
  endtask

  // main_controller model: answers each tile_start after a latency, optionally
  // also pulsing tile_done during the ISSUE cycle (must be ignored).
  int L;
  bit spur;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.tile_start) begin
        L    = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 8));
        spur = noise && ($urandom_range(0, 1) == 1);
        resp_done = spur;
        for (int k = 1; k <= L + 1; k++) begin
          @(posedge clk); #1;
          if (rst) begin
            resp_done = 1'b0;
            break;
          end
          resp_done = (k == L);
        end
      end
    end
  end

  // Monitor: pops expected tiles on tile_start, checks hold and done timing.
  tile_t cur;
  tile_t now_t;
  bit    have_cur = 1'b0;
  int    last_td = -100;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_cur = 1'b0;
      end else begin
        if (bus.tile_start) begin
          chk("tile_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            if (exp_q.size() != NT) chk("tile_gap", 64'(cyc - last_td), 64'd2);
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("ifm_base_addr", 64'(bus.ifm_base_addr), 64'(cur.ifm));
            chk("wgt_base_addr", 64'(bus.wgt_base_addr), 64'(cur.wgt));
            chk("ofm_base_addr", 64'(bus.ofm_base_addr), 64'(cur.ofm));
            chk("col_valid", 64'(bus.col_valid), 64'(cur.cv));
            chk("wgt_reload", 64'(bus.wgt_reload), 64'(cur.rl));
          end
        end else if (resp_done && have_cur) begin
          now_t = {bus.ifm_base_addr, bus.wgt_base_addr, bus.ofm_base_addr,
                   bus.col_valid, bus.wgt_reload};
          chk("hold_stable", 64'(now_t == cur), 64'd1);
          last_td = cyc;
        end
        if (done) begin
          chk("done_expected", 64'(done_got < done_req), 64'd1);
          chk("done_all_tiles", 64'(exp_q.size()), 64'd0);
          chk("done_latency", 64'(cyc - last_td), 64'd2);
          done_got++;
        end
      end
    end
  end

  task automatic start_layer();
    @(negedge clk);
    chk("idle_before_start", 64'(busy), 64'd0);
    push_layer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
`ifdef LAYER_TILE_SCHEDULER_PERF_EN
    chk("perf_clear", {cycle_cnt, tile_cnt}, 64'd0);
`endif
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        if (noise) start = ($urandom_range(0, 1) == 1);
        seen = 1'b1;
        break;
      end
      start = noise && ($urandom_range(0, 15) == 0);
    end
    chk("done_timeout", 64'(seen), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_tile_start"}, 64'(bus.tile_start), 64'd0);
    chk({tag, "_ifm"}, 64'(bus.ifm_base_addr), 64'd0);
    chk({tag, "_wgt"}, 64'(bus.wgt_base_addr), 64'd0);
    chk({tag, "_ofm"}, 64'(bus.ofm_base_addr), 64'd0);
    chk({tag, "_col_valid"}, 64'(bus.col_valid), 64'd0);
    chk({tag, "_wgt_reload"}, 64'(bus.wgt_reload), 64'd0);
`ifdef LAYER_TILE_SCHEDULER_PERF_EN
    chk({tag, "_perf"}, {cycle_cnt, tile_cnt}, 64'd0);
`endif
  endtask

  initial begin
    int ntiles;
    bit seen;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Clean layer with fixed 5-cycle tile latency.
    lat_fixed = 5;
    noise = 1'b0;
    start_layer();
    wait_done();
`ifdef LAYER_TILE_SCHEDULER_PERF_EN
    chk("cycle_cnt", 64'(cycle_cnt), 64'd57);
    chk("tile_cnt", 64'(tile_cnt), 64'd8);
`endif

    // tile_done while idle must not start anything.
    idle_done = 1'b1;
    @(negedge clk);
    idle_done = 1'b0;
    @(negedge clk);
    chk("idle_tile_done_busy", 64'(busy), 64'd0);
    chk("idle_tile_done_start", 64'(bus.tile_start), 64'd0);

    // Random latency, spurious ISSUE-cycle tile_done, start pulses while busy.
    lat_fixed = 0;
    noise = 1'b1;
    for (int n = 0; n < 4; n++) begin
      start_layer();
      wait_done();
    end

    // Reset in the WAIT phase of the fourth tile.
    noise = 1'b0;
    start_layer();
    ntiles = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.tile_start) ntiles++;
      if (ntiles == 4) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_tile4_timeout", 64'(seen), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    done_req = done_got;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", 64'(done_got), 64'(done_req));

    // Restart after the abort must begin again at tile (0,0,0).
    start_layer();
    wait_done();

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_got), 64'(done_req));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
